onectr_chunked: RTL and testbench
=================================

# onectr_chunked

Parametrised sequential bit-counter, the next generation of the single-mode ones counter. It latches an INPUTSIZE-bit word on a start handshake and processes it CHUNKSIZE bits per cycle. Selectable modes: ones count, zeros count, leading-zero count and trailing-zero count, with early termination for the zero-scan modes. It sits behind the same start/result interface as the existing counter so that the formal and simulation benches can drive either block.

## Interface
Parameters:
- INPUTSIZE, 64, width of the input word.
- CHUNKSIZE, 8, bits processed per cycle. Must divide INPUTSIZE. NCHUNK = INPUTSIZE/CHUNKSIZE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  request a new count. Accepted only when ready_o=1.
- mode_i  in  2  00 ones, 01 zeros, 10 leading zeros (MSB side), 11 trailing zeros (LSB side). Sampled with start_i.
- InPort  in  INPUTSIZE  operand. Sampled with start_i.
- ready_o  out  1  block can accept start_i (IDLE or DONE).
- done_o  out  1  OutPort holds a valid result.
- OutPort  out  $clog2(INPUTSIZE+1)  result.

## Operation
- FSM states:
  - IDLE, RUN, DONE.
  - After reset: IDLE.
  - ready_o=1 in IDLE and DONE, 0 in RUN.
  - done_o=1 only in DONE.
- Accept: start_i=1 with ready_o=1 at an edge:
  - latch InPort into an operand register and mode_i into a mode register;
  - clear the accumulator and set chunk index j=0;
  - go to RUN.
  - Input changes after acceptance have no effect.
- RUN, one chunk per cycle:
  - Modes 00/01: chunk j = bits [j*CHUNKSIZE +: CHUNKSIZE].
    - Mode 00: acc += popcount(chunk).
    - Mode 01: acc += CHUNKSIZE - popcount(chunk).
  - Mode 10: chunk j is taken from the MSB side (chunk 0 = top CHUNKSIZE bits).
    - Chunk all zero: acc += CHUNKSIZE.
    - Otherwise: acc += leading zeros of the chunk, then terminate.
  - Mode 11: same scan from the LSB side (chunk 0 = bottom bits), counting trailing zeros.
  - Terminate after chunk NCHUNK-1 or on early termination.
  - On termination, OutPort takes the final accumulator value (including this cycle's contribution) and the FSM goes to DONE.
- DONE:
  - OutPort and done_o hold until a new start is accepted.
  - Start accepted in DONE: go to RUN, done_o drops on the same edge, OutPort keeps the old value until the new result.
- start_i in RUN is ignored; there is no queueing.
- Width rules:
  - accumulator and OutPort are $clog2(INPUTSIZE+1) bits;
  - maximum value INPUTSIZE, so no overflow and no saturation needed;
  - an all-zero operand gives INPUTSIZE in modes 01/10/11.
- Reset (any state, including mid-RUN):
  - IDLE, ready_o=1, done_o=0, OutPort=0;
  - operand, mode and accumulator cleared;
  - the in-flight count is discarded.

## Timing
- Reset values: ready_o=1, done_o=0, OutPort=0.
- Start accepted at edge k:
  - modes 00/01: done_o=1 and OutPort valid after edge k+NCHUNK;
  - modes 10/11: after edge k+m+1, where m is the index of the first non-zero chunk (m=NCHUNK-1 if all zero).
- Minimum latency 1 cycle (mode 10/11, first chunk non-zero); maximum NCHUNK cycles.
- Back-to-back: a start may be accepted on the same edge that... no; start is accepted only when ready_o=1, so the earliest next start is the first edge after entering DONE. Throughput is one result per latency+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
(INPUTSIZE=64, CHUNKSIZE=8)
- Mode 00, InPort=64'hFFFF_FFFF_FFFF_FFFF -> OutPort=64, done_o rises 8 cycles after the accept edge, ready_o low for exactly those 8 cycles.
- Mode 01, InPort=64'h0000_0000_0000_00F0 -> OutPort=60 after 8 cycles. Then mode 00, same operand, started in DONE -> done_o drops next edge, OutPort stays 60 until it becomes 4.
- Mode 10:
  - InPort=64'h0000_0100_0000_0000 -> OutPort=23 after 3 cycles (early termination);
  - InPort=0 -> OutPort=64 after 8 cycles.
- Mode 11:
  - InPort=64'h1 -> OutPort=0 after 1 cycle;
  - InPort=64'h8000_0000_0000_0000 -> OutPort=63 after 8 cycles.
- Mode 00, InPort=64'h0F0F_0F0F_0F0F_0F0F accepted; during RUN, start_i held high, InPort changed to all ones and mode_i changed to 01 -> OutPort=32, exactly one result produced, and a new start is accepted only after done_o=1.
- Mode 00 started; rst asserted asynchronously mid-cycle at chunk 4 -> ready_o=1, done_o=0, OutPort=0 immediately. After release, a fresh start with InPort=64'h3 -> OutPort=2.

Source files
------------

// File: rtl/onectr_chunked_if.sv
// Start/result bus of the chunked bit counter: operand and mode in, status and count out.
interface onectr_chunked_if #(
  parameter int INPUTSIZE = 64
);
  localparam int OW = $clog2(INPUTSIZE + 1);

  logic                 start_i;
  logic [1:0]           mode_i;
  logic [INPUTSIZE-1:0] InPort;
  logic                 ready_o;
  logic                 done_o;
  logic [OW-1:0]        OutPort;

  modport master (
    output start_i, mode_i, InPort,
    input  ready_o, done_o, OutPort
  );

  modport slave (
    input  start_i, mode_i, InPort,
    output ready_o, done_o, OutPort
  );
endinterface

// File: rtl/onectr_chunked.sv
// Sequential ones/zeros/leading-zero/trailing-zero counter working CHUNKSIZE bits per cycle,
// with early termination for the zero-scan modes.
module onectr_chunked #(
  parameter int INPUTSIZE = 64,
  parameter int CHUNKSIZE = 8
) (
  input logic              clk,
  input logic              rst,
  onectr_chunked_if.slave  bus
);
  localparam int NCHUNK = INPUTSIZE / CHUNKSIZE;
  localparam int OW     = $clog2(INPUTSIZE + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [OW-1:0] CHUNK_W  = OW'(CHUNKSIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  function automatic logic [OW-1:0] popcount(input logic [CHUNKSIZE-1:0] v);
    logic [OW-1:0] n;
    n = {OW{1'b0}};
    for (int i = 0; i < CHUNKSIZE; i++) begin
      n = n + {{(OW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Ascending scan: the highest set bit is the last to overwrite, giving the leading-zero count.
  function automatic logic [OW-1:0] lead_zeros(input logic [CHUNKSIZE-1:0] v);
    logic [OW-1:0] n;
    n = CHUNK_W;
    for (int i = 0; i < CHUNKSIZE; i++) begin
      n = v[i] ? OW'(CHUNKSIZE - 1 - i) : n;
    end
    return n;
  endfunction

  function automatic logic [OW-1:0] trail_zeros(input logic [CHUNKSIZE-1:0] v);
    logic [OW-1:0] n;
    n = CHUNK_W;
    for (int i = CHUNKSIZE - 1; i >= 0; i--) begin
      n = v[i] ? OW'(i) : n;
    end
    return n;
  endfunction

  state_t               state_r, state_nx;
  logic [INPUTSIZE-1:0] opnd_r;
  logic [1:0]           mode_r;
  logic [OW-1:0]        acc_r;
  logic [OW-1:0]        out_r;
  logic [IW-1:0]        idx_r;
  logic                 ready_r;
  logic                 done_r;

  logic                 accept_s;
  logic [CHUNKSIZE-1:0] chunk_s;
  logic [OW-1:0]        add_s;
  logic [OW-1:0]        sum_s;
  logic                 early_s;
  logic                 last_s;
  logic [INPUTSIZE-1:0] opnd_nx_s;

  // Chunk selection and per-cycle contribution; the operand register shifts so the live chunk sits at one end.
  always_comb begin
    chunk_s   = (mode_r == 2'b10) ? opnd_r[INPUTSIZE-1 -: CHUNKSIZE] : opnd_r[CHUNKSIZE-1:0];
    opnd_nx_s = (mode_r == 2'b10) ? (opnd_r << CHUNKSIZE) : (opnd_r >> CHUNKSIZE);
    add_s     = {OW{1'b0}};
    early_s   = 1'b0;
    case (mode_r)
      2'b00: add_s = popcount(chunk_s);
      2'b01: add_s = CHUNK_W - popcount(chunk_s);
      2'b10: begin
        add_s   = lead_zeros(chunk_s);
        early_s = (chunk_s != {CHUNKSIZE{1'b0}});
      end
      2'b11: begin
        add_s   = trail_zeros(chunk_s);
        early_s = (chunk_s != {CHUNKSIZE{1'b0}});
      end
      default: add_s = {OW{1'b0}};
    endcase
    sum_s    = acc_r + add_s;
    last_s   = (idx_r == LAST_IDX) || early_s;
    accept_s = bus.start_i && (state_r != RUN);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_nx = RUN;
        end else begin
          state_nx = state_r;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx = DONE;
        end else begin
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_r  <= {INPUTSIZE{1'b0}};
      mode_r  <= 2'b00;
      acc_r   <= {OW{1'b0}};
      out_r   <= {OW{1'b0}};
      idx_r   <= {IW{1'b0}};
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_nx != RUN);
      done_r  <= (state_nx == DONE);
      if (accept_s) begin
        opnd_r <= bus.InPort;
        mode_r <= bus.mode_i;
        acc_r  <= {OW{1'b0}};
        idx_r  <= {IW{1'b0}};
      end else if (state_r == RUN) begin
        opnd_r <= opnd_nx_s;
        acc_r  <= sum_s;
        idx_r  <= idx_r + IDX_ONE;
        if (last_s) begin
          out_r <= sum_s;
        end
      end
    end
  end

  assign bus.ready_o = ready_r;
  assign bus.done_o  = done_r;
  assign bus.OutPort = out_r;
endmodule

// File: tb/tb_onectr_chunked.sv
// Directed bench for onectr_chunked: a result/latency model derived from the counting rules,
// a per-cycle compare process, and literal expectations for each directed case.
module tb_onectr_chunked;
  localparam int W   = 64;
  localparam int C   = 8;
  localparam int NCH = W / C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  onectr_chunked_if #(.INPUTSIZE(W)) bus ();
  onectr_chunked #(.INPUTSIZE(W), .CHUNKSIZE(C)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int exp_result(input logic [1:0] mode, input logic [W-1:0] op);
    int  n;
    bit  found;
    n = 0;
    found = 1'b0;
    case (mode)
      2'b00: n = $countones(op);
      2'b01: n = W - $countones(op);
      2'b10: for (int i = W - 1; i >= 0; i--) begin
               if (op[i]) found = 1'b1;
               if (!found) n++;
             end
      default: for (int i = 0; i < W; i++) begin
               if (op[i]) found = 1'b1;
               if (!found) n++;
             end
    endcase
    return n;
  endfunction

  // A zero scan stops in the chunk holding the first set bit; full-word modes always take NCH cycles.
  function automatic int exp_latency(input logic [1:0] mode, input logic [W-1:0] op);
    int r;
    r = exp_result(mode, op);
    if (mode[1] == 1'b0 || r == W) return NCH;
    return r / C + 1;
  endfunction

  int m_ready = 1;
  int m_done  = 0;
  int m_out   = 0;
  int m_res   = 0;
  int m_rem   = 0;

  // Transaction-level model: one pending result released after its latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1; m_done <= 0; m_out <= 0; m_rem <= 0; m_res <= 0;
    end else if (m_ready == 1 && bus.start_i) begin
      m_res   <= exp_result(bus.mode_i, bus.InPort);
      m_rem   <= exp_latency(bus.mode_i, bus.InPort);
      m_ready <= 0;
      m_done  <= 0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_out <= m_res; m_done <= 1; m_ready <= 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ready_model", int'(bus.ready_o), m_ready);
    check("done_model",  int'(bus.done_o),  m_done);
    check("out_model",   int'(bus.OutPort), m_out);
  end

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.done_o) begin
        lat = c;
        break;
      end
    end
  endtask

  // Called just after a rising edge while the block is ready.
  task automatic run(input string name, input logic [1:0] mode, input logic [W-1:0] op,
                     input int exp_val, input int exp_lat, input int hold_val);
    int lat;
    bus.start_i = 1'b1; bus.mode_i = mode; bus.InPort = op;
    @(posedge clk); #1;
    check({name, "_busy"}, int'(bus.ready_o), 0);
    check({name, "_done_drop"}, int'(bus.done_o), 0);
    check({name, "_hold"}, int'(bus.OutPort), hold_val);
    #1 bus.start_i = 1'b0;
    wait_done(lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_val"}, int'(bus.OutPort), exp_val);
  endtask

  initial begin
    int lat;
    bus.start_i = 1'b0; bus.mode_i = 2'b00; bus.InPort = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.ready_o), 1);
    check("rst_done",  int'(bus.done_o),  0);
    check("rst_out",   int'(bus.OutPort), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("ones_all",  2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64, 8, 0);
    run("zeros_f0",  2'b01, 64'h0000_0000_0000_00F0, 60, 8, 64);
    run("ones_f0",   2'b00, 64'h0000_0000_0000_00F0, 4,  8, 60);
    run("lz_early",  2'b10, 64'h0000_0100_0000_0000, 23, 3, 4);
    run("lz_zero",   2'b10, 64'h0,                   64, 8, 23);
    run("tz_one",    2'b11, 64'h1,                   0,  1, 64);
    run("tz_msb",    2'b11, 64'h8000_0000_0000_0000, 63, 8, 0);

    // Inputs changing during RUN, start held high throughout.
    bus.start_i = 1'b1; bus.mode_i = 2'b00; bus.InPort = 64'h0F0F_0F0F_0F0F_0F0F;
    @(posedge clk); #1;
    check("ign_busy", int'(bus.ready_o), 0);
    #1 bus.InPort = 64'hFFFF_FFFF_FFFF_FFFF; bus.mode_i = 2'b01;
    wait_done(lat);
    check("ign_lat", lat, 8);
    check("ign_val", int'(bus.OutPort), 32);
    @(posedge clk); #1;
    check("ign_restart_done", int'(bus.done_o), 0);
    check("ign_restart_hold", int'(bus.OutPort), 32);
    #1 bus.start_i = 1'b0;
    wait_done(lat);
    check("ign2_lat", lat, 8);
    check("ign2_val", int'(bus.OutPort), 0);

    // Asynchronous reset while chunk 4 is in flight.
    bus.start_i = 1'b1; bus.mode_i = 2'b00; bus.InPort = 64'hFF;
    @(posedge clk); #2 bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ready", int'(bus.ready_o), 1);
    check("mid_rst_done",  int'(bus.done_o),  0);
    check("mid_rst_out",   int'(bus.OutPort), 0);
    @(posedge clk); #3 rst = 1'b0;
    run("post_rst", 2'b00, 64'h3, 2, 8, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
